pc_sequencer: RTL and testbench

Parametrised program-counter unit that supersedes the plain PC register in the fetch stage.
- Selects the next PC from sequential increment, ID-stage jump, EX-stage branch and trap vector, with fixed priority.
- Holds redirects that arrive while fetch is stalled and applies them when the stall releases.
- Provides a PC+INC output and a fetch-advance counter for the pipeline and for debug.

---
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: hazard/redirect requests in, fetch PC and debug state out.
interface pc_sequencer_if #(
  parameter int unsigned DW = 32
);
  logic          PCWrite;
  logic          TrapReq;
  logic          BranchTaken;
  logic [DW-1:0] BranchTarget;
  logic          JumpEn;
  logic [DW-1:0] JumpTarget;
  logic [DW-1:0] PCResult;
  logic [DW-1:0] PCPlusInc;
  logic          RedirectPending;
  logic [DW-1:0] FetchCount;
  logic          MisalignErr;

  modport master (
    output PCWrite, TrapReq, BranchTaken, BranchTarget, JumpEn, JumpTarget,
    input  PCResult, PCPlusInc, RedirectPending, FetchCount, MisalignErr
  );

  modport slave (
    input  PCWrite, TrapReq, BranchTaken, BranchTarget, JumpEn, JumpTarget,
    output PCResult, PCPlusInc, RedirectPending, FetchCount, MisalignErr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC select (trap > branch > jump > held redirect > PC+INC); redirects land one edge after acceptance.
// PCWrite=0 stalls and parks redirects (TrapReq still applies); optional PC_ALIGN_CHECK_EN traps misaligned targets.
module pc_sequencer #(
  parameter int unsigned   DW         = 32,
  parameter logic [DW-1:0] RESET_PC   = '0,
  parameter int unsigned   INC        = 4,
  parameter logic [31:0]   TRAP_VEC   = 32'h0000_0100,
  parameter int unsigned   ALIGN_BITS = 2
) (
  input logic           Clk,
  input logic           PCReset_n,
  pc_sequencer_if.slave bus
);

  localparam logic [DW-1:0] TRAP_PC    = DW'(TRAP_VEC);
  localparam logic [DW-1:0] INC_V      = DW'(INC);
  localparam logic [DW-1:0] ONE        = DW'(1);
  localparam logic [DW-1:0] ALIGN_MASK = DW'((64'd1 << ALIGN_BITS) - 64'd1);
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic {RUN, HOLD} state_t;
  typedef enum logic {CLS_JUMP, CLS_BRANCH} cls_t;

  typedef struct packed {
    cls_t          cls;
    logic [DW-1:0] tgt;
  } pend_t;

  state_t        state_q, state_d;
  pend_t         pend_q, pend_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic          load;
  logic [DW-1:0] load_tgt;
  logic          jump_ok;

  // A new jump may only displace a held jump, never a held branch.
  assign jump_ok = bus.JumpEn && !(state_q == HOLD && pend_q.cls == CLS_BRANCH);

  always_ff @(posedge Clk or negedge PCReset_n) begin
    if (!PCReset_n) begin
      state_q <= RUN;
      pend_q  <= '0;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    mis_d    = 1'b0;
    load     = 1'b0;
    load_tgt = pc_q;

    if (bus.TrapReq) begin
      pc_d    = TRAP_PC;
      pend_d  = '0;
      state_d = RUN;
      cnt_d   = cnt_q + ONE;
    end else if (bus.PCWrite) begin
      cnt_d   = cnt_q + ONE;
      state_d = RUN;
      pend_d  = '0;
      if (bus.BranchTaken) begin
        load     = 1'b1;
        load_tgt = bus.BranchTarget;
      end else if (jump_ok) begin
        load     = 1'b1;
        load_tgt = bus.JumpTarget;
      end else if (state_q == HOLD) begin
        load     = 1'b1;
        load_tgt = pend_q.tgt;
      end else begin
        pc_d = pc_q + INC_V;
      end
    end else begin
      if (bus.BranchTaken) begin
        pend_d.cls = CLS_BRANCH;
        pend_d.tgt = bus.BranchTarget;
        state_d    = HOLD;
      end else if (jump_ok) begin
        pend_d.cls = CLS_JUMP;
        pend_d.tgt = bus.JumpTarget;
        state_d    = HOLD;
      end
    end

    // Alignment is judged on the target actually applied, so held targets are checked at release.
    if (load) begin
      if (ALIGN_CHK && |(load_tgt & ALIGN_MASK)) begin
        pc_d  = TRAP_PC;
        mis_d = 1'b1;
      end else begin
        pc_d = load_tgt;
      end
    end
  end

  assign bus.PCResult        = pc_q;
  assign bus.PCPlusInc       = pc_q + INC_V;
  assign bus.RedirectPending = (state_q == HOLD);
  assign bus.FetchCount      = cnt_q;
  assign bus.MisalignErr     = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table vectors, hand-written reset/stall sequence and randomized traffic against a behavioural PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic Clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_sequencer_if #(.DW(32)) bus ();

  pc_sequencer #(
    .DW(32), .RESET_PC(RST_PC), .INC(4), .TRAP_VEC(TRAP), .ALIGN_BITS(2)
  ) dut (
    .Clk(Clk),
    .PCReset_n(rst_n),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: PC, advance count and at most one parked redirect.
  logic [31:0] m_pc, m_cnt, m_pt;
  bit          m_pv, m_pbr, m_mis;

  task automatic model_reset();
    m_pc = RST_PC; m_cnt = 0; m_pv = 0; m_pbr = 0; m_pt = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit pcw, input bit trap, input bit br, input logic [31:0] bt,
                            input bit je, input logic [31:0] jt);
    logic [31:0] t;
    bit          redirect;
    bit          jump_allowed;
    jump_allowed = je && !(m_pv && m_pbr);
    m_mis = 0;
    if (trap) begin
      m_pc = TRAP; m_pv = 0; m_cnt = m_cnt + 1;
    end else if (pcw) begin
      redirect = 1;
      if (br) t = bt;
      else if (jump_allowed) t = jt;
      else if (m_pv) t = m_pt;
      else begin redirect = 0; t = m_pc + 4; end
      m_pv = 0;
      m_cnt = m_cnt + 1;
      if (redirect && ALIGN_ON && (t % 4) != 0) begin
        m_pc = TRAP; m_mis = 1;
      end else begin
        m_pc = t;
      end
    end else if (br) begin
      m_pv = 1; m_pbr = 1; m_pt = bt;
    end else if (jump_allowed) begin
      m_pv = 1; m_pbr = 0; m_pt = jt;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " PCResult"}, bus.PCResult, m_pc);
    chk({tag, " PCPlusInc"}, bus.PCPlusInc, m_pc + 32'd4);
    chk({tag, " RedirectPending"}, {31'b0, bus.RedirectPending}, {31'b0, m_pv});
    chk({tag, " FetchCount"}, bus.FetchCount, m_cnt);
    chk({tag, " MisalignErr"}, {31'b0, bus.MisalignErr}, {31'b0, m_mis});
  endtask

  task automatic drive(input bit pcw, input bit trap, input bit br, input logic [31:0] bt,
                       input bit je, input logic [31:0] jt);
    bus.PCWrite = pcw; bus.TrapReq = trap; bus.BranchTaken = br;
    bus.BranchTarget = bt; bus.JumpEn = je; bus.JumpTarget = jt;
  endtask

  task automatic cycle(input bit pcw, input bit trap, input bit br, input logic [31:0] bt,
                       input bit je, input logic [31:0] jt);
    drive(pcw, trap, br, bt, je, jt);
    model_step(pcw, trap, br, bt, je, jt);
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    bit          pcw, trap, br;
    logic [31:0] bt;
    bit          je;
    logic [31:0] jt;
    logic [31:0] e_pc;
    bit          e_pend;
    logic [31:0] e_cnt;
    bit          e_mis;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  initial begin
    logic [31:0] r, bt, jt, lo;
    bit          pcw, trap, br, je;

    checks = 0;
    errors = 0;

    //         pcw trap br  bt            je  jt            e_pc          pend e_cnt mis
    vt[0]  = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_1004, F, 32'd1,  F};
    vt[1]  = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_1008, F, 32'd2,  F};
    vt[2]  = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_100C, F, 32'd3,  F};
    vt[3]  = '{T, F, T, 32'h200,      T, 32'h300,      32'h0000_0200, F, 32'd4,  F};
    vt[4]  = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_0204, F, 32'd5,  F};
    vt[5]  = '{F, F, F, 32'h0,        T, 32'h300,      32'h0000_0204, T, 32'd5,  F};
    vt[6]  = '{F, F, T, 32'h200,      F, 32'h0,        32'h0000_0204, T, 32'd5,  F};
    vt[7]  = '{F, F, F, 32'h0,        T, 32'h400,      32'h0000_0204, T, 32'd5,  F};
    vt[8]  = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_0200, F, 32'd6,  F};
    vt[9]  = '{T, F, T, 32'hFFFF_FFFC, F, 32'h0,       32'hFFFF_FFFC, F, 32'd7,  F};
    vt[10] = '{T, F, F, 32'h0,        F, 32'h0,        32'h0000_0000, F, 32'd8,  F};
    vt[11] = '{F, F, F, 32'h0,        T, 32'h700,      32'h0000_0000, T, 32'd8,  F};
    vt[12] = '{F, T, F, 32'h0,        F, 32'h0,        32'h0000_0100, F, 32'd9,  F};
    vt[13] = '{F, F, F, 32'h0,        T, 32'h800,      32'h0000_0100, T, 32'd9,  F};
    vt[14] = '{F, F, F, 32'h0,        T, 32'h900,      32'h0000_0100, T, 32'd9,  F};
    vt[15] = '{T, F, F, 32'h0,        T, 32'hA00,      32'h0000_0A00, F, 32'd10, F};
    vt[16] = '{F, F, T, 32'h500,      F, 32'h0,        32'h0000_0A00, T, 32'd10, F};
    vt[17] = '{T, F, F, 32'h0,        T, 32'hB00,      32'h0000_0500, F, 32'd11, F};
    vt[18] = '{F, F, T, 32'h600,      F, 32'h0,        32'h0000_0500, T, 32'd11, F};
    vt[19] = '{T, F, T, 32'h640,      F, 32'h0,        32'h0000_0640, F, 32'd12, F};
    vt[20] = '{T, T, T, 32'h700,      T, 32'h800,      32'h0000_0100, F, 32'd13, F};
`ifdef PC_ALIGN_CHECK_EN
    vt[21] = '{T, F, F, 32'h0,        T, 32'h302,      32'h0000_0100, F, 32'd14, T};
    vt[22] = '{F, F, F, 32'h0,        F, 32'h0,        32'h0000_0100, F, 32'd14, F};
`else
    vt[21] = '{T, F, F, 32'h0,        T, 32'h302,      32'h0000_0302, F, 32'd14, F};
    vt[22] = '{F, F, F, 32'h0,        F, 32'h0,        32'h0000_0302, F, 32'd14, F};
`endif

    rst_n = 1'b0;
    drive(F, F, F, 32'h0, F, 32'h0);
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cycle(vt[i].pcw, vt[i].trap, vt[i].br, vt[i].bt, vt[i].je, vt[i].jt);
      chk($sformatf("vec%0d PCResult", i), bus.PCResult, vt[i].e_pc);
      chk($sformatf("vec%0d PCPlusInc", i), bus.PCPlusInc, vt[i].e_pc + 32'd4);
      chk($sformatf("vec%0d RedirectPending", i), {31'b0, bus.RedirectPending}, {31'b0, vt[i].e_pend});
      chk($sformatf("vec%0d FetchCount", i), bus.FetchCount, vt[i].e_cnt);
      chk($sformatf("vec%0d MisalignErr", i), {31'b0, bus.MisalignErr}, {31'b0, vt[i].e_mis});
    end

    // Held branch wiped by a mid-cycle reset; it must never reach PCResult.
    cycle(F, F, T, 32'h500, F, 32'h0);
    chk("held branch pending", {31'b0, bus.RedirectPending}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("async reset");
    #2;
    rst_n = 1'b1;
    cycle(T, F, F, 32'h0, F, 32'h0);
    chk("post-reset PC", bus.PCResult, RST_PC + 32'd4);
    chk_model("post-reset");

    // Randomized traffic; occasional misaligned targets exercise the alignment path.
    for (int n = 0; n < 3000; n++) begin
      r    = $urandom;
      pcw  = (r[1:0] != 2'b00);
      trap = (r[6:2] == 5'd0);
      br   = (r[9:7] < 3'd2);
      je   = (r[12:10] < 3'd3);
      bt   = $urandom & 32'hFFFF_FFFC;
      jt   = $urandom & 32'hFFFF_FFFC;
      lo   = $urandom;
      if (r[16:14] == 3'd0) bt = bt | (lo & 32'h3);
      if (r[19:17] == 3'd0) jt = jt | ((lo >> 2) & 32'h3);
      cycle(pcw, trap, br, bt, je, jt);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
